// File: rtl/pll_lock_sequencer_if.sv
// Signal bundle between a PLL lock sequencer and its environment.
// slave: the sequencer; master: the side that drives pll_locked and observes the outputs.
interface pll_lock_sequencer_if;
  logic       pll_locked;
  logic       pll_rst;
  logic       rst_out;
  logic       ready;
  logic [7:0] loss_count;
  logic [2:0] fsm_state;

  modport slave (
    input  pll_locked,
    output pll_rst, rst_out, ready, loss_count, fsm_state
  );

  modport master (
    output pll_locked,
    input  pll_rst, rst_out, ready, loss_count, fsm_state
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: filters a synchronized lock, holds downstream reset, then releases it.
// Optional relock watchdog: define PLL_LOCK_SEQ_WATCHDOG_EN to enable the PLLRST path.
module pll_lock_sequencer #(
  parameter int LOCK_FILTER    = 1024,
  parameter int HOLD_CYCLES    = 16,
  parameter int RELOCK_TIMEOUT = 1048576,
  parameter int PLL_RST_LEN    = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  pll_lock_sequencer_if.slave   bus
);

  localparam logic [2:0] S_WAIT   = 3'd0;
  localparam logic [2:0] S_FILTER = 3'd1;
  localparam logic [2:0] S_HOLD   = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_PLLRST = 3'd4;

  // Shared counter sized for the largest terminal count of any state.
  localparam int MAX_AB = (LOCK_FILTER > HOLD_CYCLES) ? LOCK_FILTER : HOLD_CYCLES;
  localparam int MAX_CD = (RELOCK_TIMEOUT > PLL_RST_LEN) ? RELOCK_TIMEOUT : PLL_RST_LEN;
  localparam int MAX_CNT = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] LF_LAST = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] HC_LAST = CW'(HOLD_CYCLES - 1);
`ifdef PLL_LOCK_SEQ_WATCHDOG_EN
  localparam logic [CW-1:0] TO_LAST = CW'(RELOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] PR_LAST = CW'(PLL_RST_LEN - 1);
`endif

  logic          sync1;
  logic          locked_s;
  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [CW-1:0] cnt;
  logic          cnt_run;
  logic [7:0]    loss;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1    <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync1    <= bus.pll_locked;
      locked_s <= sync1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_run   = 1'b0;
    case (state)
      S_WAIT: begin
        if (locked_s) state_nxt = S_FILTER;
`ifdef PLL_LOCK_SEQ_WATCHDOG_EN
        else if (cnt == TO_LAST) state_nxt = S_PLLRST;
        cnt_run = 1'b1;
`endif
      end
      S_FILTER: begin
        cnt_run = 1'b1;
        if (!locked_s)           state_nxt = S_WAIT;
        else if (cnt == LF_LAST) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        cnt_run = 1'b1;
        if (!locked_s)           state_nxt = S_WAIT;
        else if (cnt == HC_LAST) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!locked_s) state_nxt = S_WAIT;
      end
      S_PLLRST: begin
`ifdef PLL_LOCK_SEQ_WATCHDOG_EN
        cnt_run = 1'b1;
        if (cnt == PR_LAST) state_nxt = S_WAIT;
`else
        state_nxt = S_WAIT;
`endif
      end
      default: state_nxt = S_WAIT;
    endcase
  end

  // Counter clears on any state change, so each state counts from zero on entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_WAIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) cnt <= '0;
      else if (cnt_run)       cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      loss <= '0;
    end else if (state == S_RUN && !locked_s && loss != 8'hFF) begin
      loss <= loss + 8'd1;
    end
  end

  assign bus.rst_out    = (state != S_RUN);
  assign bus.ready      = (state == S_RUN);
  assign bus.fsm_state  = state;
  assign bus.loss_count = loss;
`ifdef PLL_LOCK_SEQ_WATCHDOG_EN
  assign bus.pll_rst    = (state == S_PLLRST);
`else
  assign bus.pll_rst    = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed, table-driven bench for pll_lock_sequencer (LOCK_FILTER=4, HOLD_CYCLES=3,
// RELOCK_TIMEOUT=20, PLL_RST_LEN=2); watchdog section follows PLL_LOCK_SEQ_WATCHDOG_EN.
module tb_pll_lock_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pll_lock_sequencer_if bus ();

  pll_lock_sequencer #(
    .LOCK_FILTER    (4),
    .HOLD_CYCLES    (3),
    .RELOCK_TIMEOUT (20),
    .PLL_RST_LEN    (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       lock;
    logic [2:0] st;
    logic [7:0] loss;
  } vec_t;

  vec_t vecs[$];
  int   exp_loss;

  task automatic add(input logic lock, input logic [2:0] st, input logic [7:0] loss, input int n);
    vec_t v;
    v.lock = lock;
    v.st   = st;
    v.loss = loss;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Drop the lock, expect rst_out within 3 edges, then relock and expect ready on edge 10.
  task automatic lose_and_relock(input int want_loss);
    int n;
    bus.pll_locked = 1'b0;
    for (n = 1; n <= 3; n++) begin
      step();
      if (bus.rst_out) break;
    end
    chk("drop_rst_out", int'(bus.rst_out), 1);
    chk("drop_loss_count", int'(bus.loss_count), want_loss);
    bus.pll_locked = 1'b1;
    for (n = 1; n <= 20; n++) begin
      step();
      if (bus.ready) break;
    end
    chk("relock_latency", n, 10);
  endtask

  initial begin
    int n;
    // Clean lock: sampled high on edge 10, RUN after edge 19.
    add(1'b0, 3'd0, 8'd0, 9);
    add(1'b1, 3'd0, 8'd0, 2);
    add(1'b1, 3'd1, 8'd0, 4);
    add(1'b1, 3'd2, 8'd0, 3);
    add(1'b1, 3'd3, 8'd0, 3);
    // Loss in RUN: low sampled at edge 22, WAIT_LOCK after edge 24.
    add(1'b0, 3'd3, 8'd0, 2);
    add(1'b0, 3'd0, 8'd1, 1);
    add(1'b1, 3'd0, 8'd1, 2);
    add(1'b1, 3'd1, 8'd1, 1);
    // Two-cycle glitch while in FILTER restarts the whole count.
    add(1'b0, 3'd1, 8'd1, 2);
    add(1'b1, 3'd0, 8'd1, 2);
    add(1'b1, 3'd1, 8'd1, 4);
    add(1'b1, 3'd2, 8'd1, 3);
    add(1'b1, 3'd3, 8'd1, 2);

    bus.pll_locked = 1'b0;
    step();
    step();
    chk("reset_rst_out", int'(bus.rst_out), 1);
    chk("reset_ready", int'(bus.ready), 0);
    chk("reset_state", int'(bus.fsm_state), 0);
    chk("reset_loss", int'(bus.loss_count), 0);
    chk("reset_pll_rst", int'(bus.pll_rst), 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      bus.pll_locked = vecs[i].lock;
      step();
      chk($sformatf("vec%0d_state", i + 1), int'(bus.fsm_state), int'(vecs[i].st));
      chk($sformatf("vec%0d_rst_out", i + 1), int'(bus.rst_out), int'(vecs[i].st != 3'd3));
      chk($sformatf("vec%0d_ready", i + 1), int'(bus.ready), int'(vecs[i].st == 3'd3));
      chk($sformatf("vec%0d_loss", i + 1), int'(bus.loss_count), int'(vecs[i].loss));
      chk($sformatf("vec%0d_pll_rst", i + 1), int'(bus.pll_rst), 0);
    end

    lose_and_relock(2);
    lose_and_relock(3);

    exp_loss = 3;
    for (int i = 0; i < 300; i++) begin
      exp_loss = (exp_loss < 255) ? exp_loss + 1 : 255;
      lose_and_relock(exp_loss);
    end
    chk("loss_saturated", int'(bus.loss_count), 255);

    // Async reset in HOLD, applied between edges.
    bus.pll_locked = 1'b0;
    step();
    step();
    step();
    bus.pll_locked = 1'b1;
    for (n = 1; n <= 20; n++) begin
      step();
      if (bus.fsm_state == 3'd2) break;
    end
    chk("reach_hold", int'(bus.fsm_state), 2);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_out", int'(bus.rst_out), 1);
    chk("async_ready", int'(bus.ready), 0);
    chk("async_state", int'(bus.fsm_state), 0);
    chk("async_loss", int'(bus.loss_count), 0);
    step();
    step();
    chk("held_reset_state", int'(bus.fsm_state), 0);
    reset = 1'b0;
    for (n = 1; n <= 20; n++) begin
      step();
      if (bus.ready) break;
    end
    chk("post_reset_latency", n, 10);
    chk("post_reset_loss", int'(bus.loss_count), 0);

    reset = 1'b1;
    bus.pll_locked = 1'b0;
    step();
    reset = 1'b0;
`ifdef PLL_LOCK_SEQ_WATCHDOG_EN
    for (int e = 1; e <= 66; e++) begin
      step();
      chk($sformatf("wd_pll_rst_e%0d", e), int'(bus.pll_rst),
          int'(e >= 20 && ((e - 20) % 22) < 2));
    end
`else
    for (int e = 1; e <= 1000; e++) begin
      step();
      chk($sformatf("nowd_pll_rst_e%0d", e), int'(bus.pll_rst), 0);
      chk($sformatf("nowd_state_e%0d", e), int'(bus.fsm_state), 0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
